// File: rtl/axil_uart_regs.sv
// axil_uart_regs - AXI4-Lite slave register front-end for a UART core.
// Register map, decoded on addr[3:2]:
//   0x0 RX   (RO)  pops one byte from the UART RX FIFO, SLVERR when empty
//   0x4 TX   (WO)  pushes one byte into the UART TX FIFO, SLVERR when full
//   0x8 STAT (RO)  bit0 = RX data available, bit3 = TX full, bit4 = IRQ enable
//   0xC CTRL (RW)  bit4 = interrupt enable
// Optional build macro AXIL_UART_WSTRB_EN: when defined, TX and CTRL writes
// only take effect if WSTRB[0] is set; otherwise WSTRB is ignored.
module axil_uart_regs #(
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            Clk,
    input  logic                            Reset,
    // write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    // write response channel
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    // read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    // read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    // UART RX FIFO (show-ahead)
    input  logic [7:0]                      RX_data,
    input  logic                            Empty,
    output logic                            rd_uart_en,
    // UART TX FIFO
    output logic [7:0]                      TX_data,
    output logic                            wr_uart_en,
    input  logic                            Full,
    // level interrupt
    output logic                            Interrupt
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] REG_RX   = 2'd0;
    localparam logic [1:0] REG_TX   = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    wstate_t                          r_wstate;
    wstate_t                          w_wstate_next;
    logic                             r_aw_held;
    logic                             r_w_held;
    logic [1:0]                       r_aw_reg;
    logic [7:0]                       r_wdata_lo;
    logic                             r_wstrb0;
    logic                             r_ctrl_ie;
    logic [7:0]                       r_tx_data;
    logic                             r_wr_uart_en;
    logic [1:0]                       r_bresp;
    logic                             r_irq;

    logic                             w_aw_hs;
    logic                             w_w_hs;
    logic                             w_exec;
    logic                             w_strb_ok;
    logic                             w_push;
    logic                             w_ctrl_wr;
    logic [1:0]                       w_bresp_next;

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    rstate_t                          r_rstate;
    rstate_t                          w_rstate_next;
    logic [C_S_AXI_DATA_WIDTH-1:0]    r_rdata;
    logic [1:0]                       r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0]    w_rdata_next;
    logic [1:0]                       w_rresp_next;
    logic                             w_ar_hs;
    logic                             w_pop;

    // Address bits outside [3:2], upper data bits and most strobes carry no meaning here.
    logic                             w_unused;
    assign w_unused = &{1'b0, S_AXI_AWADDR, S_AXI_ARADDR,
                        S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:8], S_AXI_WSTRB, r_wstrb0};

`ifdef AXIL_UART_WSTRB_EN
    assign w_strb_ok = r_wstrb0;
`else
    assign w_strb_ok = 1'b1;
`endif

    // Readies are forced low while Reset is held so no handshake (and hence
    // no pop) can slip through in the first reset cycle.
    assign S_AXI_AWREADY = ~Reset & (r_wstate == W_IDLE) & ~r_aw_held;
    assign S_AXI_WREADY  = ~Reset & (r_wstate == W_IDLE) & ~r_w_held;
    assign S_AXI_ARREADY = ~Reset & (r_rstate == R_IDLE);

    assign w_aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    assign S_AXI_BVALID = (r_wstate == W_RESP);
    assign S_AXI_BRESP  = r_bresp;
    assign S_AXI_RVALID = (r_rstate == R_DATA);
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = r_rresp;

    assign TX_data    = r_tx_data;
    assign wr_uart_en = r_wr_uart_en;
    assign rd_uart_en = w_pop;
    assign Interrupt  = r_irq;

    // Write FSM next state: execute once address and data are both held.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_wstate_next = r_wstate;
        w_exec        = 1'b0;
        w_push        = 1'b0;
        w_ctrl_wr     = 1'b0;
        w_bresp_next  = r_bresp;
        case (r_wstate)
            W_IDLE: begin
                if (r_aw_held && r_w_held) begin
                    w_exec        = 1'b1;
                    w_wstate_next = W_RESP;
                    w_bresp_next  = RESP_OKAY;
                    if (r_aw_reg == REG_TX && w_strb_ok) begin
                        if (Full) begin
                            w_bresp_next = RESP_SLVERR;
                        end else begin
                            w_push = 1'b1;
                        end
                    end
                    if (r_aw_reg == REG_CTRL && w_strb_ok) begin
                        w_ctrl_wr = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_wstate_next = W_IDLE;
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_next;
        end
    end

    // Write datapath: latch AW and W independently, then push / update CTRL on execute.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_aw_held    <= 1'b0;
            r_w_held     <= 1'b0;
            r_aw_reg     <= 2'd0;
            r_wdata_lo   <= 8'd0;
            r_wstrb0     <= 1'b0;
            r_ctrl_ie    <= 1'b0;
            r_tx_data    <= 8'd0;
            r_wr_uart_en <= 1'b0;
            r_bresp      <= RESP_OKAY;
        end else begin
            r_wr_uart_en <= w_push;
            r_bresp      <= w_bresp_next;
            if (w_exec) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_reg  <= S_AXI_AWADDR[3:2];
                end
                if (w_w_hs) begin
                    r_w_held   <= 1'b1;
                    r_wdata_lo <= S_AXI_WDATA[7:0];
                    r_wstrb0   <= S_AXI_WSTRB[0];
                end
            end
            if (w_push) begin
                r_tx_data <= r_wdata_lo;
            end
            if (w_ctrl_wr) begin
                r_ctrl_ie <= r_wdata_lo[4];
            end
        end
    end

    // Read FSM next state and response data; the RX pop fires in the AR handshake cycle.
    always_comb begin
        w_rstate_next = r_rstate;
        w_rdata_next  = r_rdata;
        w_rresp_next  = r_rresp;
        w_pop         = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rstate_next = R_DATA;
                    w_rdata_next  = '0;
                    w_rresp_next  = RESP_OKAY;
                    case (S_AXI_ARADDR[3:2])
                        REG_RX: begin
                            if (Empty) begin
                                w_rresp_next = RESP_SLVERR;
                            end else begin
                                w_rdata_next[7:0] = RX_data;
                                w_pop             = 1'b1;
                            end
                        end
                        REG_STAT: begin
                            w_rdata_next[0] = ~Empty;
                            w_rdata_next[3] = Full;
                            w_rdata_next[4] = r_ctrl_ie;
                        end
                        REG_CTRL: begin
                            w_rdata_next[4] = r_ctrl_ie;
                        end
                        default: begin
                            w_rdata_next = '0;
                        end
                    endcase
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    w_rstate_next = R_IDLE;
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    // Read FSM state register plus registered RDATA/RRESP.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_next;
            r_rdata  <= w_rdata_next;
            r_rresp  <= w_rresp_next;
        end
    end

    // Registered level interrupt: enabled and either RX has data or TX has room.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ctrl_ie & (~Empty | ~Full);
        end
    end

endmodule

// File: tb/tb_axil_uart_regs.sv
// tb_axil_uart_regs - directed plus randomized bench for axil_uart_regs.
// The UART FIFOs are modelled by a byte queue (RX) and a push log (TX);
// expected responses come from a register-map model of the device.
module tb_axil_uart_regs;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

`ifdef AXIL_UART_WSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic [3:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [7:0]  RX_data;
    logic        Empty;
    logic        rd_uart_en;
    logic [7:0]  TX_data;
    logic        wr_uart_en;
    logic        Full;
    logic        Interrupt;

    axil_uart_regs #(
        .C_S_AXI_ADDR_WIDTH(4),
        .C_S_AXI_DATA_WIDTH(32)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .RX_data(RX_data), .Empty(Empty), .rd_uart_en(rd_uart_en),
        .TX_data(TX_data), .wr_uart_en(wr_uart_en), .Full(Full),
        .Interrupt(Interrupt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int         checks = 0;
    int         errors = 0;
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    logic [7:0] last_tx = 8'h00;
    logic [7:0] rx_q[$];
    logic       m_ie = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void drive_rx();
        Empty   = (rx_q.size() == 0);
        RX_data = Empty ? 8'hEE : rx_q[0];
    endfunction

    // One clock: count strobes at the falling edge, then apply the RX pop after the rising edge.
    task automatic tick();
        bit popped;
        @(negedge Clk);
        popped = rd_uart_en;
        if (rd_uart_en) rd_cnt++;
        if (wr_uart_en) begin
            wr_cnt++;
            last_tx = TX_data;
        end
        @(posedge Clk);
        #1;
        if (popped && rx_q.size() > 0) rx_q.delete(0);
        drive_rx();
    endtask

    // Register-map model of a read.
    function automatic void model_read(input logic [3:0] a, output logic [31:0] d,
                                       output logic [1:0] r, output int pop);
        d = 32'h0; r = OKAY; pop = 0;
        case (a[3:2])
            2'd0: begin
                if (rx_q.size() == 0) r = SLVERR;
                else begin d = {24'h0, rx_q[0]}; pop = 1; end
            end
            2'd2: d = (rx_q.size() != 0 ? 32'h1 : 32'h0) + (Full ? 32'h8 : 32'h0) + (m_ie ? 32'h10 : 32'h0);
            2'd3: d = m_ie ? 32'h10 : 32'h0;
            default: d = 32'h0;
        endcase
    endfunction

    // Register-map model of a write; updates the modelled enable bit.
    function automatic void model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                                        output logic [1:0] b, output int push);
        bit en;
        en = STRB_EN ? s[0] : 1'b1;
        b = OKAY; push = 0;
        if (a[3:2] == 2'd1 && en) begin
            if (Full) b = SLVERR;
            else push = 1;
        end
        if (a[3:2] == 2'd3 && en) m_ie = d[4];
    endfunction

    // Drives an optional write and an optional read concurrently, with per-channel delays.
    task automatic axi_txn(
        input bit do_wr, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] ws,
        input int aw_d, input int w_d, input int b_d,
        input bit do_rd, input logic [3:0] ra, input int ar_d, input int r_d,
        output logic [1:0] bresp, output logic [31:0] rdata, output logic [1:0] rresp,
        output int pushes, output int pops,
        output logic irq_at_b, output logic irq_after, output logic push_at_b);
        int cyc, bwait, rwait, wr0, rd0;
        bit aw_done, w_done, b_done, b_seen, ar_done, r_done, r_seen;
        cyc = 0; bwait = 0; rwait = 0; wr0 = wr_cnt; rd0 = rd_cnt;
        aw_done = !do_wr; w_done = !do_wr; b_done = !do_wr; b_seen = 0;
        ar_done = !do_rd; r_done = !do_rd; r_seen = 0;
        bresp = 2'b00; rdata = 32'h0; rresp = 2'b00; irq_at_b = 1'b0; push_at_b = 1'b0;
        S_AXI_AWADDR = wa; S_AXI_WDATA = wd; S_AXI_WSTRB = ws; S_AXI_ARADDR = ra;
        while (!(b_done && r_done) && cyc < 100) begin
            S_AXI_AWVALID = !aw_done && cyc >= aw_d;
            S_AXI_WVALID  = !w_done && cyc >= w_d;
            S_AXI_ARVALID = !ar_done && cyc >= ar_d;
            S_AXI_BREADY  = 1'b0;
            S_AXI_RREADY  = 1'b0;
            if (!b_done && S_AXI_BVALID) begin
                if (!b_seen) begin
                    irq_at_b  = Interrupt;
                    push_at_b = wr_uart_en;
                end
                b_seen = 1;
                check("aw_w_ready_low_during_b", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'(0));
                if (bwait >= b_d) begin
                    S_AXI_BREADY = 1'b1;
                    bresp = S_AXI_BRESP;
                    b_done = 1;
                end
                bwait++;
            end else if (b_seen && !b_done) begin
                check("bvalid_held", 64'(S_AXI_BVALID), 64'(1));
            end
            if (!r_done && S_AXI_RVALID) begin
                r_seen = 1;
                check("arready_low_during_r", 64'(S_AXI_ARREADY), 64'(0));
                if (rwait >= r_d) begin
                    S_AXI_RREADY = 1'b1;
                    rdata = S_AXI_RDATA;
                    rresp = S_AXI_RRESP;
                    r_done = 1;
                end
                rwait++;
            end else if (r_seen && !r_done) begin
                check("rvalid_held", 64'(S_AXI_RVALID), 64'(1));
            end
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
            if (S_AXI_ARVALID && S_AXI_ARREADY) ar_done = 1;
            tick();
            cyc++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        check("txn_completed_in_budget", 64'(b_done && r_done), 64'(1));
        pushes = wr_cnt - wr0;
        pops = rd_cnt - rd0;
        irq_after = Interrupt;
    endtask

    // Model-predicted transaction followed by full response and interrupt checks.
    task automatic run(
        input bit do_wr, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] ws,
        input int aw_d, input int w_d, input int b_d,
        input bit do_rd, input logic [3:0] ra, input int ar_d, input int r_d,
        output logic [1:0] bresp, output logic [31:0] rdata, output logic [1:0] rresp,
        output logic irq_at_b, output logic irq_after);
        logic [31:0] e_rdata;
        logic [1:0]  e_rresp, e_bresp;
        int          e_pop, e_push, pushes, pops;
        logic        push_at_b;
        e_rdata = 32'h0; e_rresp = OKAY; e_pop = 0; e_bresp = OKAY; e_push = 0;
        if (do_rd) model_read(ra, e_rdata, e_rresp, e_pop);
        if (do_wr) model_write(wa, wd, ws, e_bresp, e_push);
        axi_txn(do_wr, wa, wd, ws, aw_d, w_d, b_d, do_rd, ra, ar_d, r_d,
                bresp, rdata, rresp, pushes, pops, irq_at_b, irq_after, push_at_b);
        if (do_wr) begin
            check("bresp", 64'(bresp), 64'(e_bresp));
            if (e_push != 0) begin
                check("push_with_bvalid", 64'(push_at_b), 64'(1));
                check("tx_data", 64'(last_tx), 64'(wd[7:0]));
            end
        end
        check("push_count", 64'(pushes), 64'(e_push));
        if (do_rd) begin
            check("rdata", 64'(rdata), 64'(e_rdata));
            check("rresp", 64'(rresp), 64'(e_rresp));
        end
        check("pop_count", 64'(pops), 64'(e_pop));
        tick();
        check("interrupt_level", 64'(Interrupt), 64'(m_ie && (rx_q.size() != 0 || !Full)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [1:0]  o_b, o_r;
    logic [31:0] o_d;
    logic        o_ia, o_if;
    int          rd0;

    initial begin
        Reset = 1'b1;
        S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0; Full = 1'b1;
        drive_rx();

        // Reset held two cycles: every output low.
        tick();
        tick();
        check("reset_handshake_outputs",
              64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                   S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP}), 64'(0));
        check("reset_rdata", 64'(S_AXI_RDATA), 64'(0));
        check("reset_uart_outputs", 64'({rd_uart_en, TX_data, wr_uart_en, Interrupt}), 64'(0));
        Reset = 1'b0;
        tick();
        check("post_reset_valids", 64'({S_AXI_BVALID, S_AXI_RVALID, rd_uart_en, wr_uart_en, Interrupt}), 64'(0));

        // STAT read with Full=1, Empty=1.
        run(0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 1, 4'h8, 0, 0, o_b, o_d, o_r, o_ia, o_if);
        check("stat_reset_value", 64'(o_d), 64'(32'h8));

        // TX write, AW and W together, room in the TX FIFO.
        Full = 1'b0;
        run(1, 4'h4, 32'h0000_00A5, 4'hF, 0, 0, 0, 0, 4'h0, 0, 0, o_b, o_d, o_r, o_ia, o_if);
        check("tx_write_okay", 64'(o_b), 64'(OKAY));
        check("tx_byte_a5", 64'(last_tx), 64'(8'hA5));

        // TX write with AW three cycles ahead of W while full; BREADY held low 5 cycles.
        Full = 1'b1;
        run(1, 4'h4, 32'h0000_00C3, 4'hF, 0, 3, 5, 0, 4'h0, 0, 0, o_b, o_d, o_r, o_ia, o_if);
        check("tx_full_slverr", 64'(o_b), 64'(SLVERR));

        // Drain two RX bytes, then read an empty FIFO.
        rx_q.push_back(8'h37);
        rx_q.push_back(8'h38);
        drive_rx();
        rd0 = rd_cnt;
        run(0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 0, o_b, o_d, o_r, o_ia, o_if);
        check("rx_first", 64'({o_d, o_r}), 64'({32'h37, OKAY}));
        run(0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 1, 4'h0, 1, 2, o_b, o_d, o_r, o_ia, o_if);
        check("rx_second", 64'({o_d, o_r}), 64'({32'h38, OKAY}));
        run(0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 0, o_b, o_d, o_r, o_ia, o_if);
        check("rx_empty", 64'({o_d, o_r}), 64'({32'h0, SLVERR}));
        check("rx_pop_total", 64'(rd_cnt - rd0), 64'(2));

        // Interrupt enable on then off, one-cycle registered latency.
        rx_q.push_back(8'h41);
        drive_rx();
        run(1, 4'hC, 32'h0000_0010, 4'hF, 0, 0, 0, 0, 4'h0, 0, 0, o_b, o_d, o_r, o_ia, o_if);
        check("irq_low_at_execute", 64'(o_ia), 64'(0));
        check("irq_high_next_cycle", 64'(o_if), 64'(1));
        run(0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 1, 4'hC, 0, 0, o_b, o_d, o_r, o_ia, o_if);
        check("ctrl_readback", 64'(o_d), 64'(32'h10));
        run(1, 4'hC, 32'h0000_0000, 4'hF, 0, 0, 0, 0, 4'h0, 0, 0, o_b, o_d, o_r, o_ia, o_if);
        check("irq_high_at_execute", 64'(o_ia), 64'(1));
        check("irq_low_next_cycle", 64'(o_if), 64'(0));

        // RX pop and TX push landing in the same cycle.
        Full = 1'b0;
        run(1, 4'h4, 32'h0000_005A, 4'hF, 0, 0, 0, 1, 4'h0, 2, 0, o_b, o_d, o_r, o_ia, o_if);
        check("concurrent_okay", 64'({o_b, o_r}), 64'({OKAY, OKAY}));

        // TX write with WSTRB=0 (push suppressed only when strobes are honoured).
        run(1, 4'h4, 32'h0000_0077, 4'h0, 1, 0, 1, 0, 4'h0, 0, 0, o_b, o_d, o_r, o_ia, o_if);

        // Randomized traffic against the register-map model.
        for (int i = 0; i < 60; i++) begin
            bit          do_wr, do_rd;
            int          kind;
            logic [3:0]  wa, ra;
            Full = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) rx_q.push_back(8'($urandom));
            drive_rx();
            kind  = $urandom_range(0, 2);
            do_wr = (kind != 1);
            do_rd = (kind != 0);
            wa = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            ra = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if (do_wr && do_rd && wa[3:2] == 2'd3 && ra[3] == 1'b1) ra = 4'h0;
            run(do_wr, wa, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                do_rd, ra, $urandom_range(0, 3), $urandom_range(0, 3),
                o_b, o_d, o_r, o_ia, o_if);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
